// File: rtl/ghost_motion_driver.sv
// ghost_motion_driver
//   Autonomous video-slot bus initiator that animates one ghost sprite. At
//   the start of every vertical blank it moves the ghost (bouncing off the
//   visible-area edges), steps an animation phase, and writes x0, y0 and
//   ctrl into the sprite core. After reset it first writes bypass = 0 and
//   then publishes the start position and ctrl without waiting for a frame.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   x, y                  frame-counter pixel coordinates
//   enable                motion enable (frame triggers ignored when low)
//   speed_x, speed_y      pixels moved per frame (0 = hold)
//   ctrl_base             ctrl value; bit 0 replaced by animation phase
//   bus_req / bus_gnt     video-slot bus request / grant
//   cs, write             video-slot strobes (combinational from bus_gnt)
//   addr, wr_data         video-slot address / write data
//   busy                  high whenever the FSM is not idle
//   overrun               sticky: a frame trigger arrived while busy
module ghost_motion_driver #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned SPRITE_W    = 16,
  parameter int unsigned SPRITE_H    = 16,
  parameter int unsigned START_X     = 100,
  parameter int unsigned START_Y     = 200,
  parameter int unsigned ANIM_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        enable,
  input  logic [2:0]  speed_x,
  input  logic [2:0]  speed_y,
  input  logic [4:0]  ctrl_base,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        cs,
  output logic        write,
  output logic [13:0] addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        overrun
);

  localparam logic [11:0] X_MAX = 12'(H_ACTIVE - SPRITE_W);
  localparam logic [11:0] Y_MAX = 12'(V_ACTIVE - SPRITE_H);

  localparam int unsigned   CNT_W    = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_FRAMES - 1);

  localparam logic [13:0] ADDR_BYP  = 14'h2000;
  localparam logic [13:0] ADDR_X0   = 14'h2001;
  localparam logic [13:0] ADDR_Y0   = 14'h2002;
  localparam logic [13:0] ADDR_CTRL = 14'h2003;

  typedef enum logic [2:0] {
    ST_INIT_BYP,
    ST_WR_X,
    ST_WR_Y,
    ST_WR_C,
    ST_IDLE,
    ST_UPDATE
  } state_e;

  state_e           state_q,     state_d;
  logic [10:0]      x_pos_q,     x_pos_d;
  logic [10:0]      y_pos_q,     y_pos_d;
  logic             dir_x_q,     dir_x_d;
  logic             dir_y_q,     dir_y_d;
  logic             anim_ph_q,   anim_ph_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             cond_q,      cond_d;
  logic             overrun_q,   overrun_d;

  logic cond;
  logic trig;
  logic wr_slot;

  // One axis of bouncing motion. Returns {dir, pos}. Comparisons use 12-bit
  // operands so pos + speed can never wrap. A zero speed holds both position
  // and direction, even in the corner case of sitting exactly on a wall.
  function automatic logic [11:0] axis_step(
    input logic [10:0] pos,
    input logic        dir,
    input logic [2:0]  spd,
    input logic [11:0] lim
  );
    logic [11:0] pos_w;
    logic [11:0] spd_w;
    logic [11:0] sum;
    pos_w     = {1'b0, pos};
    spd_w     = {9'd0, spd};
    sum       = pos_w + spd_w;
    axis_step = {dir, pos};
    if (spd != 3'd0) begin
      if (!dir) begin
        if (sum >= lim) axis_step = {1'b1, lim[10:0]};
        else            axis_step = {1'b0, sum[10:0]};
      end else begin
        if (pos_w <= spd_w) axis_step = {1'b0, 11'd0};
        else                axis_step = {1'b1, pos - {8'd0, spd}};
      end
    end
  endfunction

  // Rising edge of the start-of-vblank condition: one trigger per frame no
  // matter how many clocks a pixel lasts.
  assign cond = (x == 11'd0) && (y == 11'(V_ACTIVE));
  assign trig = cond & ~cond_q;

  always_comb begin
    state_d     = state_q;
    x_pos_d     = x_pos_q;
    y_pos_d     = y_pos_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    anim_ph_d   = anim_ph_q;
    frame_cnt_d = frame_cnt_q;
    cond_d      = cond;
    overrun_d   = overrun_q;

    if (trig && (state_q != ST_IDLE)) overrun_d = 1'b1;

    case (state_q)
      ST_INIT_BYP: if (bus_gnt) state_d = ST_WR_X;
      ST_WR_X:     if (bus_gnt) state_d = ST_WR_Y;
      ST_WR_Y:     if (bus_gnt) state_d = ST_WR_C;
      ST_WR_C:     if (bus_gnt) state_d = ST_IDLE;
      ST_IDLE:     if (trig && enable) state_d = ST_UPDATE;
      ST_UPDATE: begin
        {dir_x_d, x_pos_d} = axis_step(x_pos_q, dir_x_q, speed_x, X_MAX);
        {dir_y_d, y_pos_d} = axis_step(y_pos_q, dir_y_q, speed_y, Y_MAX);
        if (frame_cnt_q == CNT_LAST) begin
          frame_cnt_d = '0;
          anim_ph_d   = ~anim_ph_q;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
        state_d = ST_WR_X;
      end
      default: state_d = ST_INIT_BYP;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT_BYP;
      x_pos_q     <= 11'(START_X);
      y_pos_q     <= 11'(START_Y);
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b0;
      anim_ph_q   <= 1'b0;
      frame_cnt_q <= '0;
      cond_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_pos_q     <= x_pos_d;
      y_pos_q     <= y_pos_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      anim_ph_q   <= anim_ph_d;
      frame_cnt_q <= frame_cnt_d;
      cond_q      <= cond_d;
      overrun_q   <= overrun_d;
    end
  end

  // Bus side. The FSM rests in INIT_BYP during reset, so the slot outputs
  // are also qualified by reset_n to keep the bus quiet until release.
  always_comb begin
    wr_slot = 1'b0;
    addr    = '0;
    wr_data = '0;
    case (state_q)
      ST_INIT_BYP: begin
        wr_slot = 1'b1;
        addr    = ADDR_BYP;
      end
      ST_WR_X: begin
        wr_slot = 1'b1;
        addr    = ADDR_X0;
        wr_data = {21'd0, x_pos_q};
      end
      ST_WR_Y: begin
        wr_slot = 1'b1;
        addr    = ADDR_Y0;
        wr_data = {21'd0, y_pos_q};
      end
      ST_WR_C: begin
        wr_slot = 1'b1;
        addr    = ADDR_CTRL;
        wr_data = {27'd0, ctrl_base[4:1], anim_ph_q};
      end
      default: ;
    endcase
    if (!reset_n) begin
      wr_slot = 1'b0;
      addr    = '0;
      wr_data = '0;
    end
    bus_req = wr_slot;
    cs      = wr_slot & bus_gnt;
    write   = wr_slot & bus_gnt;
  end

  assign busy    = (state_q != ST_IDLE);
  assign overrun = overrun_q;

endmodule

// File: doc/ghost_motion_driver.md
# ghost_motion_driver

Autonomous bus initiator that animates a ghost sprite without CPU involvement. Once per video frame, at the start of vertical blank, it advances the ghost position with wall bouncing, steps an animation phase, and issues register writes into a sprite core's video-slot interface (cs/write/addr/wr_data). It sits between the video-slot bus arbiter and the sprite core, on the writer side of the slot the sprite core receives on.

## Interface

Parameters:
- H_ACTIVE, 640, visible width in pixels
- V_ACTIVE, 480, visible height; the frame trigger fires at y == V_ACTIVE
- SPRITE_W, 16, ghost width; X_MAX = H_ACTIVE − SPRITE_W
- SPRITE_H, 16, ghost height; Y_MAX = V_ACTIVE − SPRITE_H
- START_X, 100, x position after reset
- START_Y, 200, y position after reset
- ANIM_FRAMES, 8, frames per animation-phase toggle (≥1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- x, y  in  11 each  frame-counter pixel coordinates
- enable  in  1  motion enable; when low, triggers are ignored
- speed_x, speed_y  in  3 each  pixels moved per frame (0 = hold)
- ctrl_base  in  5  ctrl value; bit 0 is replaced by the animation phase
- bus_req  out  1  request for the video-slot bus
- bus_gnt  in  1  grant from the arbiter; sampled every cycle
- cs, write  out  1 each  video-slot strobes
- addr  out  14  video-slot address
- wr_data  out  32  video-slot write data
- busy  out  1  high whenever state ≠ IDLE
- overrun  out  1  sticky flag: a trigger arrived while busy

## Operation

- Register map written: 14'h2000 bypass (data 0), 14'h2001 x0, 14'h2002 y0, 14'h2003 ctrl. wr_data carries zero-extended values: x0/y0 in [10:0], ctrl in [4:0].
- Frame trigger: cond = (x == 0) && (y == V_ACTIVE). A registered copy cond_d gives a rising-edge trigger, trig = cond & ~cond_d, so there is exactly one trigger per frame regardless of pixel-tick rate.
- FSM states: INIT_BYP → WR_X → WR_Y → WR_C → IDLE; IDLE → UPDATE on (trig & enable); UPDATE → WR_X.
- Reset state is INIT_BYP. After reset, the block publishes bypass = 0 and then the start position and ctrl, without waiting for a frame.
- UPDATE performs one cycle of arithmetic, evaluated separately for each axis. Using x as the example, with 12-bit intermediates and no overflow:
  - dir_x = 0 (moving right): if x_pos + speed_x ≥ X_MAX, set x_pos ← X_MAX and dir_x ← 1; otherwise x_pos ← x_pos + speed_x.
  - dir_x = 1 (moving left): if x_pos ≤ speed_x, set x_pos ← 0 and dir_x ← 0; otherwise x_pos ← x_pos − speed_x.
  - The y axis behaves the same way with speed_y, Y_MAX and dir_y.
- Speed 0 leaves position and direction unchanged, but all writes are still issued.
- Animation: frame_cnt increments in UPDATE. When it reaches ANIM_FRAMES−1 it wraps to 0 and anim_ph toggles. The ctrl write data is {ctrl_base[4:1], anim_ph}.
- Write handshake: in each WR_* state bus_req = 1, and addr/wr_data are driven with that state's register.
  - cs = write = bus_gnt, so the strobes are combinational from the grant.
  - The state advances only on a cycle where bus_gnt = 1.
  - With bus_gnt low, the FSM holds and addr/wr_data stay stable.
- Outside the WR_* states: bus_req = cs = write = 0, addr = 0, wr_data = 0.
- A trigger arriving while busy is dropped and sets overrun; the sequence in progress completes unchanged.
- enable falling mid-sequence has no effect on that sequence.

## Timing

- Reset values: bus_req 0, cs 0, write 0, addr 0, wr_data 0, overrun 0. Internal registers reset to x_pos = START_X, y_pos = START_Y, dir_x = dir_y = 0, anim_ph = 0, frame_cnt = 0, cond_d = 0.
- busy is 1 during reset because the FSM sits in INIT_BYP.
- Reset asserted mid-sequence aborts immediately. No strobe is emitted while reset_n = 0, and the full init sequence restarts after release.
- With bus_gnt held high after reset release, cycle 0 is the first clk edge with reset_n = 1:
  - Writes land on cycles 0, 1, 2 and 3 (bypass, x0, y0, ctrl).
  - busy falls in cycle 4.
- Frame latency, taking C as the cycle cond first becomes true:
  - UPDATE in C+1.
  - WR_X, WR_Y and WR_C in C+2, C+3 and C+4 with a continuous grant.
  - IDLE in C+5.
  - Each cycle of grant withholding adds one cycle.
- A trigger coinciding with busy falling (the WR_C cycle with grant) still counts as busy: it is dropped and sets overrun.

## Test plan

- Reset release with bus_gnt = 1 → cs/write high for exactly 4 cycles, with (addr, data) = (2000, 0), (2001, 100), (2002, 200), (2003, ctrl_base & 5'h1E); bus_req then drops.
- enable = 1, speed_x = 4, speed_y = 1, one frame sweep → x0 data 104, y0 data 201, writes at C+2..C+4.
- Bounce: x_pos = 622, right, speed_x = 4 → x0 = 624 and dir flips; next frame 620. Left case: x_pos = 3, speed 4 → 0, then 4.
- bus_gnt low for 3 cycles while in WR_Y → bus_req stays 1, cs = 0, addr holds 2002; the y0 write occurs on the first granted cycle and the total sequence is 3 cycles longer.
- Force cond high again while busy (gnt low) → no second sequence, overrun = 1 sticky until reset_n low.
- ANIM_FRAMES = 2, 6 frames → ctrl bit 0 sequence 0,1,1,0,0,1 (toggles after every second frame); enable = 0 frames produce no writes.
